// File: rtl/clock_set_controller.sv
// Front-panel time-set controller for the digital clock.
// Moves between RUN / SET_HOUR / SET_MIN on debounced push-buttons, issues
// single-cycle increment pulses (with auto-repeat) to the hour/minute counters,
// gates the seconds chain and generates the display blink enables.
module clock_set_controller #(
    parameter int unsigned REPEAT_DELAY  = 16,
    parameter int unsigned REPEAT_PERIOD = 8,
    parameter int unsigned TIMEOUT_TICKS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       run_en,
    output logic       hour_inc,
    output logic       min_inc,
    output logic       sec_clear,
    output logic [1:0] mode,
    output logic       blink_hour,
    output logic       blink_min
);

    // Repeat counter must hold whichever repeat interval is longer.
    localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                      : REPEAT_PERIOD;
    localparam int unsigned RepW   = $clog2(RepMax) + 1;
    localparam int unsigned ToW    = $clog2(TIMEOUT_TICKS) + 1;

    localparam logic [RepW-1:0] RepDelay  = RepW'(REPEAT_DELAY);
    localparam logic [RepW-1:0] RepPeriod = RepW'(REPEAT_PERIOD);
    localparam logic [ToW-1:0]  ToLast    = ToW'(TIMEOUT_TICKS - 1);

    // Encoding doubles as the mode output.
    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StSetHour = 2'b01,
        StSetMin  = 2'b10
    } state_e;

    state_e state_q, state_d;

    // Button conditioning.
    logic [1:0] mode_sync_q;
    logic [1:0] inc_sync_q;
    logic       mode_prev_q;
    logic       inc_prev_q;
    logic       mode_edge;
    logic       inc_edge;
    logic       inc_level;

    // Auto-repeat. rep_arm_q is only set by a fresh inc edge inside a SET mode,
    // so a button already held across a mode change or reset never repeats.
    logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
    logic            rep_arm_q, rep_arm_d;
    logic            rep_phase_q, rep_phase_d;   // 0: waiting delay, 1: periodic
    logic            inc_pulse;

    // Timeout and blink.
    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic           timeout_hit;
    logic           phase_q, phase_d;
    logic           in_set;

    // Registered outputs.
    logic run_en_q, run_en_d;
    logic hour_inc_q, hour_inc_d;
    logic min_inc_q, min_inc_d;
    logic sec_clear_q, sec_clear_d;
    logic blink_hour_q, blink_hour_d;
    logic blink_min_q, blink_min_d;

    // Two-flop synchronizers plus previous-value flops for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_sync_q <= 2'b00;
            inc_sync_q  <= 2'b00;
            mode_prev_q <= 1'b0;
            inc_prev_q  <= 1'b0;
        end else begin
            mode_sync_q <= {mode_sync_q[0], btn_mode};
            inc_sync_q  <= {inc_sync_q[0], btn_inc};
            mode_prev_q <= mode_sync_q[1];
            inc_prev_q  <= inc_sync_q[1];
        end
    end

    assign mode_edge = mode_sync_q[1] & ~mode_prev_q;
    assign inc_edge  = inc_sync_q[1] & ~inc_prev_q;
    assign inc_level = inc_sync_q[1];
    assign in_set    = (state_q != StRun);

    // Timeout counter: cleared by any button activity, advanced by tick in SET modes.
    always_comb begin
        to_cnt_d    = to_cnt_q;
        timeout_hit = 1'b0;
        if (!in_set || mode_edge || inc_level) begin
            to_cnt_d = '0;
        end else if (tick) begin
            if (to_cnt_q == ToLast) begin
                timeout_hit = 1'b1;
                to_cnt_d    = '0;
            end else begin
                to_cnt_d = to_cnt_q + ToW'(1);
            end
        end
    end

    // Mode FSM next state; a mode edge takes priority over a timeout.
    always_comb begin
        state_d     = state_q;
        sec_clear_d = 1'b0;
        if (mode_edge) begin
            unique case (state_q)
                StRun:     state_d = StSetHour;
                StSetHour: state_d = StSetMin;
                StSetMin: begin
                    state_d     = StRun;
                    sec_clear_d = 1'b1;
                end
                default:   state_d = StRun;
            endcase
        end else if (timeout_hit) begin
            state_d = StRun;
        end
    end

    // Increment pulse and auto-repeat counter.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_arm_d   = rep_arm_q;
        rep_phase_d = rep_phase_q;
        inc_pulse   = 1'b0;
        if (!in_set || mode_edge || !inc_level) begin
            // RUN, a mode change or release all cancel any pending repeat.
            rep_cnt_d   = '0;
            rep_arm_d   = 1'b0;
            rep_phase_d = 1'b0;
        end else if (inc_edge) begin
            inc_pulse   = 1'b1;
            rep_arm_d   = 1'b1;
            rep_phase_d = 1'b0;
            rep_cnt_d   = RepW'(1);
        end else if (rep_arm_q) begin
            // rep_cnt_q equals cycles since the last pulse.
            if ((!rep_phase_q && rep_cnt_q == RepDelay) ||
                (rep_phase_q && rep_cnt_q == RepPeriod)) begin
                inc_pulse   = 1'b1;
                rep_phase_d = 1'b1;
                rep_cnt_d   = RepW'(1);
            end else begin
                rep_cnt_d = rep_cnt_q + RepW'(1);
            end
        end
    end

    // Blink phase and output next-values.
    always_comb begin
        phase_d = phase_q;
        if (state_d != state_q || state_q == StRun) begin
            phase_d = 1'b0;
        end else if (tick) begin
            phase_d = ~phase_q;
        end
        run_en_d     = (state_d == StRun);
        hour_inc_d   = inc_pulse && (state_q == StSetHour);
        min_inc_d    = inc_pulse && (state_q == StSetMin);
        blink_hour_d = (state_d == StSetHour) && phase_d && !inc_level;
        blink_min_d  = (state_d == StSetMin) && phase_d && !inc_level;
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StRun;
            rep_cnt_q    <= '0;
            rep_arm_q    <= 1'b0;
            rep_phase_q  <= 1'b0;
            to_cnt_q     <= '0;
            phase_q      <= 1'b0;
            run_en_q     <= 1'b1;
            hour_inc_q   <= 1'b0;
            min_inc_q    <= 1'b0;
            sec_clear_q  <= 1'b0;
            blink_hour_q <= 1'b0;
            blink_min_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rep_cnt_q    <= rep_cnt_d;
            rep_arm_q    <= rep_arm_d;
            rep_phase_q  <= rep_phase_d;
            to_cnt_q     <= to_cnt_d;
            phase_q      <= phase_d;
            run_en_q     <= run_en_d;
            hour_inc_q   <= hour_inc_d;
            min_inc_q    <= min_inc_d;
            sec_clear_q  <= sec_clear_d;
            blink_hour_q <= blink_hour_d;
            blink_min_q  <= blink_min_d;
        end
    end

    assign mode       = state_q;
    assign run_en     = run_en_q;
    assign hour_inc   = hour_inc_q;
    assign min_inc    = min_inc_q;
    assign sec_clear  = sec_clear_q;
    assign blink_hour = blink_hour_q;
    assign blink_min  = blink_min_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller (REPEAT_DELAY=8, REPEAT_PERIOD=4, TIMEOUT_TICKS=3).
module tb_clock_set_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       run_en;
    logic       hour_inc;
    logic       min_inc;
    logic       sec_clear;
    logic [1:0] mode;
    logic       blink_hour;
    logic       blink_min;

    int errors = 0;
    int checks = 0;

    // Running pulse tallies, sampled on the falling edge.
    int hour_seen = 0;
    int min_seen  = 0;
    int sclr_seen = 0;

    clock_set_controller #(
        .REPEAT_DELAY (8),
        .REPEAT_PERIOD(4),
        .TIMEOUT_TICKS(3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .run_en    (run_en),
        .hour_inc  (hour_inc),
        .min_inc   (min_inc),
        .sec_clear (sec_clear),
        .mode      (mode),
        .blink_hour(blink_hour),
        .blink_min (blink_min)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (hour_inc === 1'b1) hour_seen = hour_seen + 1;
        if (min_inc === 1'b1) min_seen = min_seen + 1;
        if (sec_clear === 1'b1) sclr_seen = sclr_seen + 1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Press and release the mode button; the mode change lands on the 3rd edge.
    task automatic press_mode();
        btn_mode = 1'b1;
        repeat (3) cyc();
        btn_mode = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic test_reset();
        cyc();
        cyc();
        checks++;
        if ({mode, run_en} !== 3'b001) begin
            errors++;
            $display("FAIL reset_mode_run: got mode=%b run_en=%b want 00/1", mode, run_en);
        end
        checks++;
        if ({hour_inc, min_inc, sec_clear, blink_hour, blink_min} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b%b%b%b%b want 00000",
                     hour_inc, min_inc, sec_clear, blink_hour, blink_min);
        end
        reset = 1'b1;
        repeat (3) cyc();
        checks++;
        if ({mode, run_en, hour_inc, min_inc, sec_clear} !== 6'b001000) begin
            errors++;
            $display("FAIL post_reset_idle: got mode=%b run_en=%b pulses=%b%b%b want 00/1/000",
                     mode, run_en, hour_inc, min_inc, sec_clear);
        end
    endtask

    task automatic test_mode_cycling();
        int s0;
        s0 = sclr_seen;
        press_mode();
        checks++;
        if ({mode, run_en} !== 3'b010 || sclr_seen != s0) begin
            errors++;
            $display("FAIL cycle_to_hour: got mode=%b run_en=%b sclr=%0d want 01/0/0",
                     mode, run_en, sclr_seen - s0);
        end
        press_mode();
        checks++;
        if ({mode, run_en} !== 3'b100 || sclr_seen != s0) begin
            errors++;
            $display("FAIL cycle_to_min: got mode=%b run_en=%b sclr=%0d want 10/0/0",
                     mode, run_en, sclr_seen - s0);
        end
        // Third press: watch the exact edge for sec_clear.
        btn_mode = 1'b1;
        repeat (3) cyc();
        checks++;
        if ({mode, run_en, sec_clear} !== 4'b0011) begin
            errors++;
            $display("FAIL cycle_to_run: got mode=%b run_en=%b sec_clear=%b want 00/1/1",
                     mode, run_en, sec_clear);
        end
        btn_mode = 1'b0;
        repeat (3) cyc();
        checks++;
        if (sclr_seen - s0 != 1) begin
            errors++;
            $display("FAIL sec_clear_count: got %0d want 1", sclr_seen - s0);
        end
    endtask

    task automatic test_single_inc();
        int h0;
        int m0;
        press_mode();
        h0 = hour_seen;
        m0 = min_seen;
        btn_inc = 1'b1;
        cyc();
        cyc();
        checks++;
        if (hour_inc !== 1'b0) begin
            errors++;
            $display("FAIL inc_early: got hour_inc=%b after 2 edges want 0", hour_inc);
        end
        cyc();
        checks++;
        if (hour_inc !== 1'b1) begin
            errors++;
            $display("FAIL inc_latency: got hour_inc=%b after 3 edges want 1", hour_inc);
        end
        btn_inc = 1'b0;
        repeat (8) cyc();
        checks++;
        if (hour_seen - h0 != 1 || min_seen - m0 != 0) begin
            errors++;
            $display("FAIL single_inc_count: got hour=%0d min=%0d want 1/0",
                     hour_seen - h0, min_seen - m0);
        end
    endtask

    task automatic test_auto_repeat();
        int   m0;
        logic exp_p;
        press_mode();
        checks++;
        if (mode !== 2'b10) begin
            errors++;
            $display("FAIL repeat_enter_min: got mode=%b want 10", mode);
        end
        m0 = min_seen;
        btn_inc = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            // Hold cycle k shows its pulse after edge 3+k (iteration 2+k).
            exp_p = (i == 2) || (i >= 10 && i <= 30 && ((i - 10) % 4) == 0);
            checks++;
            if ({hour_inc, min_inc} !== {1'b0, exp_p}) begin
                errors++;
                $display("FAIL repeat_pulse[%0d]: got hour=%b min=%b want 0/%b",
                         i, hour_inc, min_inc, exp_p);
            end
            if (i == 29) btn_inc = 1'b0;
        end
        checks++;
        if (min_seen - m0 != 7) begin
            errors++;
            $display("FAIL repeat_count: got %0d want 7", min_seen - m0);
        end
    endtask

    task automatic test_timeout();
        int s0;
        s0 = sclr_seen;
        press_mode();
        checks++;
        if (mode !== 2'b00 || sclr_seen - s0 != 1) begin
            errors++;
            $display("FAIL timeout_prep: got mode=%b sclr=%0d want 00/1", mode, sclr_seen - s0);
        end
        press_mode();
        s0 = sclr_seen;
        pulse_tick();
        checks++;
        if ({mode, blink_hour, blink_min} !== 4'b0110) begin
            errors++;
            $display("FAIL tick1: got mode=%b blink=%b%b want 01/10", mode, blink_hour, blink_min);
        end
        repeat (2) cyc();
        pulse_tick();
        checks++;
        if ({mode, blink_hour} !== 3'b010) begin
            errors++;
            $display("FAIL tick2: got mode=%b blink_hour=%b want 01/0", mode, blink_hour);
        end
        repeat (2) cyc();
        pulse_tick();
        checks++;
        if ({mode, run_en, sec_clear} !== 4'b0010) begin
            errors++;
            $display("FAIL tick3_timeout: got mode=%b run_en=%b sec_clear=%b want 00/1/0",
                     mode, run_en, sec_clear);
        end
        repeat (2) cyc();
        checks++;
        if (sclr_seen - s0 != 0) begin
            errors++;
            $display("FAIL timeout_sclr: got %0d want 0", sclr_seen - s0);
        end
        // Holding inc keeps the timeout from expiring.
        press_mode();
        btn_inc = 1'b1;
        for (int t = 0; t < 5; t++) begin
            repeat (3) cyc();
            pulse_tick();
        end
        checks++;
        if ({mode, blink_hour} !== 3'b010) begin
            errors++;
            $display("FAIL hold_no_timeout: got mode=%b blink_hour=%b want 01/0",
                     mode, blink_hour);
        end
        btn_inc = 1'b0;
        repeat (4) cyc();
        press_mode();
        press_mode();
        checks++;
        if (mode !== 2'b00) begin
            errors++;
            $display("FAIL timeout_exit: got mode=%b want 00", mode);
        end
    endtask

    task automatic test_simultaneous();
        int h0;
        h0 = hour_seen;
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        repeat (3) cyc();
        checks++;
        if ({mode, hour_inc} !== 3'b010) begin
            errors++;
            $display("FAIL simul_mode_wins: got mode=%b hour_inc=%b want 01/0", mode, hour_inc);
        end
        btn_mode = 1'b0;
        repeat (20) cyc();
        checks++;
        if (hour_seen - h0 != 0 || mode !== 2'b01) begin
            errors++;
            $display("FAIL simul_no_repeat: got hour=%0d mode=%b want 0/01",
                     hour_seen - h0, mode);
        end
        btn_inc = 1'b0;
        repeat (4) cyc();
        press_mode();
        press_mode();
    endtask

    task automatic test_run_ignore();
        int h0;
        int m0;
        h0 = hour_seen;
        m0 = min_seen;
        btn_inc = 1'b1;
        repeat (20) cyc();
        checks++;
        if (hour_seen - h0 != 0 || min_seen - m0 != 0 || {mode, run_en} !== 3'b001) begin
            errors++;
            $display("FAIL run_ignore: got hour=%0d min=%0d mode=%b run_en=%b want 0/0/00/1",
                     hour_seen - h0, min_seen - m0, mode, run_en);
        end
        btn_inc = 1'b0;
        repeat (4) cyc();
    endtask

    task automatic test_reset_mid();
        int h0;
        int m0;
        press_mode();
        press_mode();
        m0 = min_seen;
        btn_inc = 1'b1;
        repeat (12) cyc();
        checks++;
        if (min_seen - m0 != 2) begin
            errors++;
            $display("FAIL pre_reset_pulses: got %0d want 2", min_seen - m0);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({mode, run_en, hour_inc, min_inc, sec_clear, blink_hour, blink_min} !== 8'b00100000)
        begin
            errors++;
            $display("FAIL mid_reset_async: got mode=%b run_en=%b outs=%b%b%b%b%b",
                     mode, run_en, hour_inc, min_inc, sec_clear, blink_hour, blink_min);
        end
        cyc();
        reset = 1'b1;
        h0 = hour_seen;
        m0 = min_seen;
        repeat (10) cyc();
        checks++;
        if (hour_seen - h0 != 0 || min_seen - m0 != 0 || mode !== 2'b00) begin
            errors++;
            $display("FAIL post_reset_held: got hour=%0d min=%0d mode=%b want 0/0/00",
                     hour_seen - h0, min_seen - m0, mode);
        end
        press_mode();
        repeat (20) cyc();
        checks++;
        if (hour_seen - h0 != 0 || mode !== 2'b01) begin
            errors++;
            $display("FAIL held_into_set: got hour=%0d mode=%b want 0/01", hour_seen - h0, mode);
        end
        btn_inc = 1'b0;
        repeat (4) cyc();
        btn_inc = 1'b1;
        repeat (3) cyc();
        checks++;
        if (hour_inc !== 1'b1) begin
            errors++;
            $display("FAIL repress_pulse: got hour_inc=%b want 1", hour_inc);
        end
        btn_inc = 1'b0;
        repeat (4) cyc();
        checks++;
        if (hour_seen - h0 != 1) begin
            errors++;
            $display("FAIL repress_count: got %0d want 1", hour_seen - h0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mode_cycling();
        test_single_inc();
        test_auto_repeat();
        test_timeout();
        test_simultaneous();
        test_run_ignore();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
- Front-panel time-set controller for the digital clock.
- Sequences the hour and minute counters through RUN / SET_HOUR / SET_MIN modes, driven by two debounced push-buttons.
- Issues single-cycle increment pulses that feed the counters' carry/increment inputs, and gates the seconds chain.
- Sits between the button debouncers and the sec/min/hour counter chain; also provides display blink enables.

Parameters:
- REPEAT_DELAY, 16, clk cycles inc must be held before the first auto-repeat pulse (≥2)
- REPEAT_PERIOD, 8, clk cycles between subsequent auto-repeat pulses (≥2)
- TIMEOUT_TICKS, 10, tick pulses with no button activity in a SET mode before automatic return to RUN (≥1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle blink/timeout time base pulse (2 Hz strobe)
- btn_mode  in  1  debounced mode button, active-high, asynchronous to clk
- btn_inc  in  1  debounced increment button, active-high, asynchronous to clk
- run_en  out  1  1 in RUN: seconds chain may advance
- hour_inc  out  1  one-cycle pulse: hour counter +1
- min_inc  out  1  one-cycle pulse: minute counter +1
- sec_clear  out  1  one-cycle pulse: zero the seconds counter
- mode  out  2  00 RUN, 01 SET_HOUR, 10 SET_MIN (11 never driven)
- blink_hour  out  1  hour digits blanked when 1
- blink_min  out  1  minute digits blanked when 1

Behaviour:
- Reset (reset=0, asynchronous):
  - state RUN; mode=00, run_en=1.
  - All pulse outputs 0, blink_* 0.
  - Synchronizers, repeat counter, timeout counter and blink phase all 0.
  - Reset mid-SET abandons the SET mode with no pulses issued.
- Input conditioning:
  - Each button passes through a 2-flop synchronizer, then rising-edge detection (sync2 & ~prev).
  - An edge-driven action registers on the 3rd rising clk edge after the button is first sampled high.
  - All outputs are registered.
- FSM transitions:
  - RUN --mode edge--> SET_HOUR
  - SET_HOUR --mode edge--> SET_MIN
  - SET_MIN --mode edge--> RUN, with sec_clear=1 for that one cycle.
  - SET_HOUR or SET_MIN --timeout--> RUN, sec_clear=0.
- run_en = (state==RUN); it drops in the same cycle mode leaves 00.
- Increment, in SET_HOUR (drives hour_inc) or SET_MIN (drives min_inc):
  - An inc rising edge gives one pulse.
  - Continuous hold (sync2=1) counts clk cycles from the edge. A further pulse fires when the count reaches REPEAT_DELAY, then every REPEAT_PERIOD cycles while held.
  - Release clears the repeat counter.
  - A press never produces more than one pulse per cycle.
- inc in RUN is ignored: no pulses, and no repeat counting.
- Simultaneous mode and inc edges: mode wins, the inc edge is discarded, and the repeat counter clears. An inc still held after the mode change does not auto-repeat until it is released and pressed again.
- Timeout:
  - The counter clears on any button edge, and continuously while inc is held.
  - It increments on each tick in SET states. On reaching TIMEOUT_TICKS it returns to RUN and the counter clears.
  - The counter is held at 0 in RUN.
  - If the mode edge and the timeout fall in the same cycle, the mode edge wins.
- Blink:
  - phase toggles on each tick in SET states and is forced to 0 in RUN and on every mode change.
  - blink_hour = (SET_HOUR & phase); blink_min = (SET_MIN & phase).
  - Blinking is suppressed (0) while inc is held.
- Wrap-around of hour 23→0 and minute 59→0 is handled by the counters; the controller never inspects count values.
- Counter widths: $clog2 of the respective parameter + 1; no overflow is possible by construction.

Test Plan (REPEAT_DELAY=8, REPEAT_PERIOD=4, TIMEOUT_TICKS=3):
- Mode cycling: after reset, three separate btn_mode presses → mode goes 00→01→10→00. Exactly one sec_clear pulse, on the 10→00 transition; run_en=0 only while mode≠00.
- Single increment: in SET_HOUR, inc held 3 cycles → exactly one hour_inc, 3 clk edges after assertion; min_inc stays 0.
- Auto-repeat: in SET_MIN, inc held 30 cycles → min_inc pulses at hold cycles 0, 8, 12, 16, 20, 24, 28 (7 pulses); release → no further pulses.
- Timeout: enter SET_HOUR, no buttons, 3 tick pulses → mode=00 after the 3rd tick, sec_clear stays 0. With inc held throughout, 5 ticks → remains in 01.
- Simultaneous / ignore: mode and inc edges in the same cycle from RUN → mode=01, zero hour_inc. inc pressed in RUN → no pulses.
- Reset mid-operation: in SET_MIN during auto-repeat, pulse reset low 1 cycle → mode=00, run_en=1, all pulses 0. Button still held after reset → no pulse until released and re-pressed in a SET mode.
